// File: rtl/axi_llc_tag_bist_checker_if.sv
// Bundle of the BIST requester, functional requester, SRAM macro and
// result signals around the LLC tag BIST checker. The checker uses the
// slave modport; the tag generator, lookup and SRAM side use master.
interface axi_llc_tag_bist_checker_if #(
    parameter int NumWays      = 8,
    parameter int IndexWidth   = 10,
    parameter int PatternWidth = 20
);
    logic                            bist_req_i;
    logic                            bist_we_i;
    logic [IndexWidth-1:0]           bist_index_i;
    logic [PatternWidth-1:0]         bist_pattern_i;
    logic                            fn_req_i;
    logic                            fn_we_i;
    logic [NumWays-1:0]              fn_way_i;
    logic [IndexWidth-1:0]           fn_index_i;
    logic [PatternWidth-1:0]         fn_wdata_i;
    logic                            fn_gnt_o;
    logic [NumWays*PatternWidth-1:0] fn_rdata_o;
    logic                            fn_rvalid_o;
    logic [NumWays-1:0]              sram_req_o;
    logic [NumWays-1:0]              sram_we_o;
    logic [IndexWidth-1:0]           sram_index_o;
    logic [PatternWidth-1:0]         sram_wdata_o;
    logic [NumWays*PatternWidth-1:0] sram_rdata_i;
    logic [NumWays-1:0]              bist_res_o;
    logic                            bist_res_valid_o;
    logic                            fail_clr_i;
    logic [NumWays-1:0]              fail_o;

    modport slave (
        input  bist_req_i, bist_we_i, bist_index_i, bist_pattern_i,
        input  fn_req_i, fn_we_i, fn_way_i, fn_index_i, fn_wdata_i,
        input  sram_rdata_i, fail_clr_i,
        output fn_gnt_o, fn_rdata_o, fn_rvalid_o,
        output sram_req_o, sram_we_o, sram_index_o, sram_wdata_o,
        output bist_res_o, bist_res_valid_o, fail_o
    );

    modport master (
        output bist_req_i, bist_we_i, bist_index_i, bist_pattern_i,
        output fn_req_i, fn_we_i, fn_way_i, fn_index_i, fn_wdata_i,
        output sram_rdata_i, fail_clr_i,
        input  fn_gnt_o, fn_rdata_o, fn_rvalid_o,
        input  sram_req_o, sram_we_o, sram_index_o, sram_wdata_o,
        input  bist_res_o, bist_res_valid_o, fail_o
    );
endinterface

// File: rtl/axi_llc_tag_bist_checker.sv
// LLC tag SRAM access arbiter and BIST result checker.
//
// Handshakes: the functional requester raises fn_req_i and holds it with
// stable fields until it sees fn_gnt_o high in the same cycle; the access
// is taken in that cycle. A BIST request is always taken in the cycle it is
// raised. bist_res_valid_o and fn_rvalid_o are single-cycle strobes with no
// backpressure: the consumer must take the data in the cycle they are high.
module axi_llc_tag_bist_checker #(
    parameter int NumWays      = 8,
    parameter int IndexWidth   = 10,
    parameter int PatternWidth = 20,
    parameter int SramLatency  = 1
) (
    input logic                     clk_i,
    input logic                     rst_i,
    axi_llc_tag_bist_checker_if.slave bus
);
    logic                    rd_issue;
    logic [SramLatency-1:0]  vld_q;
    logic [SramLatency-1:0]  src_q;
    logic [PatternWidth-1:0] exp_q [SramLatency];
    logic                    last_bist;
    logic                    last_fn;
    logic [NumWays-1:0]      match;
    logic [NumWays-1:0]      res_q;
    logic                    res_valid_q;
    logic [NumWays*PatternWidth-1:0] fn_rdata_q;
    logic                    fn_rvalid_q;
    logic [NumWays-1:0]      fail_q;

    // Arbitration: BIST owns the macros whenever it asks; otherwise the
    // functional port drives only the selected ways.
    always_comb begin
        bus.fn_gnt_o     = bus.fn_req_i & ~bus.bist_req_i;
        bus.sram_req_o   = '0;
        bus.sram_we_o    = '0;
        bus.sram_index_o = '0;
        bus.sram_wdata_o = '0;
        rd_issue         = 1'b0;
        if (bus.bist_req_i) begin
            bus.sram_req_o   = '1;
            bus.sram_we_o    = {NumWays{bus.bist_we_i}};
            bus.sram_index_o = bus.bist_index_i;
            bus.sram_wdata_o = bus.bist_pattern_i;
            rd_issue         = ~bus.bist_we_i;
        end else if (bus.fn_req_i) begin
            bus.sram_req_o   = bus.fn_way_i;
            bus.sram_we_o    = bus.fn_way_i & {NumWays{bus.fn_we_i}};
            bus.sram_index_o = bus.fn_index_i;
            bus.sram_wdata_o = bus.fn_wdata_i;
            rd_issue         = ~bus.fn_we_i;
        end
    end

    // Response valid pipeline: only reads travel, reset drops in-flight reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_issue;
            for (int i = 1; i < SramLatency; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Source and expected-pattern pipeline travelling alongside the valids.
    always_ff @(posedge clk_i) begin
        src_q[0] <= bus.bist_req_i;
        exp_q[0] <= bus.bist_pattern_i;
        for (int i = 1; i < SramLatency; i++) begin
            src_q[i] <= src_q[i-1];
            exp_q[i] <= exp_q[i-1];
        end
    end

    assign last_bist = vld_q[SramLatency-1] & src_q[SramLatency-1];
    assign last_fn   = vld_q[SramLatency-1] & ~src_q[SramLatency-1];

    // Per-way compare of returning read data against the delayed pattern.
    always_comb begin
        match = '0;
        for (int w = 0; w < NumWays; w++) begin
            match[w] = (bus.sram_rdata_i[w*PatternWidth +: PatternWidth]
                        == exp_q[SramLatency-1]);
        end
    end

    // Compare stage: strobe clears when idle, result bits hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= last_bist;
            if (last_bist) begin
                res_q <= match;
            end
        end
    end

    // Functional read return: data holds between strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fn_rdata_q  <= '0;
            fn_rvalid_q <= 1'b0;
        end else begin
            fn_rvalid_q <= last_fn;
            if (last_fn) begin
                fn_rdata_q <= bus.sram_rdata_i;
            end
        end
    end

    // Sticky failure flags; a new failure beats a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fail_q <= '0;
        end else begin
            fail_q <= (fail_q & ~{NumWays{bus.fail_clr_i}})
                    | (res_valid_q ? ~res_q : '0);
        end
    end

    assign bus.bist_res_o       = res_q;
    assign bus.bist_res_valid_o = res_valid_q;
    assign bus.fn_rdata_o       = fn_rdata_q;
    assign bus.fn_rvalid_o      = fn_rvalid_q;
    assign bus.fail_o           = fail_q;
endmodule

// File: tb/tb_axi_llc_tag_bist_checker.sv
// Bench for the LLC tag BIST checker: directed scenarios plus random traffic,
// all checked each cycle against a memory-level reference model.
module tb_axi_llc_tag_bist_checker;
    localparam int NW  = 4;
    localparam int IW  = 10;
    localparam int PW  = 20;
    localparam int LAT = 3;
    localparam int DW  = NW * PW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_llc_tag_bist_checker_if #(.NumWays(NW), .IndexWidth(IW), .PatternWidth(PW)) bus ();

    axi_llc_tag_bist_checker #(
        .NumWays(NW), .IndexWidth(IW), .PatternWidth(PW), .SramLatency(LAT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // ---------------- SRAM macro model (with fault injection) ----------------
    logic [PW-1:0] sram_mem [NW][1024] = '{default: '0};
    logic [DW-1:0] rd_pipe [LAT] = '{default: '0};
    logic [DW-1:0] corrupt;

    always @(posedge clk) begin
        for (int s = LAT - 1; s > 0; s--) rd_pipe[s] <= rd_pipe[s-1];
        for (int w = 0; w < NW; w++) begin
            if (bus.sram_req_o[w]) begin
                if (bus.sram_we_o[w]) sram_mem[w][bus.sram_index_o] <= bus.sram_wdata_o;
                else rd_pipe[0][w*PW +: PW] <= sram_mem[w][bus.sram_index_o];
            end
        end
    end
    assign bus.sram_rdata_i = rd_pipe[LAT-1] ^ corrupt;

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int failures  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [PW-1:0] ref_mem [NW][1024] = '{default: '0};
    logic [NW-1:0] bist_exp_q[$];
    int            bist_due_q[$];
    logic [DW-1:0] fn_exp_q[$];
    logic [DW-1:0] fn_mask_q[$];
    int            fn_due_q[$];
    logic [NW-1:0] fail_ref = '0;
    int            b_cnt = 0;
    int            f_cnt = 0;
    bit            mon_en = 1'b0;

    // Per-cycle monitor: checks arbitration outputs, due responses and the
    // sticky flags, then records this cycle's accesses into the model.
    always @(negedge clk) begin : monitor
        logic [NW-1:0] req_e, we_e, fails, res_e;
        logic [DW-1:0] d_e, m_e;
        int idx;
        if (mon_en) begin
            req_e = '0;
            we_e  = '0;
            if (bus.bist_req_i) begin
                req_e = '1;
                we_e  = {NW{bus.bist_we_i}};
            end else if (bus.fn_req_i) begin
                req_e = bus.fn_way_i;
                we_e  = bus.fn_way_i & {NW{bus.fn_we_i}};
            end
            check("fn_gnt", bus.fn_gnt_o, bus.fn_req_i & ~bus.bist_req_i);
            check("sram_req_we", {bus.sram_req_o, bus.sram_we_o}, {req_e, we_e});

            fails = '0;
            if (bus.bist_res_valid_o === 1'b1) b_cnt++;
            if (bus.fn_rvalid_o === 1'b1) f_cnt++;
            if (bist_due_q.size() > 0 && bist_due_q[0] == cyc) begin
                check("bist_res_valid", bus.bist_res_valid_o, 1'b1);
                check("bist_res", bus.bist_res_o, bist_exp_q[0]);
                fails = ~bist_exp_q[0];
                void'(bist_due_q.pop_front());
                void'(bist_exp_q.pop_front());
            end else begin
                check("bist_res_valid", bus.bist_res_valid_o, 1'b0);
            end
            if (fn_due_q.size() > 0 && fn_due_q[0] == cyc) begin
                check("fn_rvalid", bus.fn_rvalid_o, 1'b1);
                check("fn_rdata", bus.fn_rdata_o & fn_mask_q[0], fn_exp_q[0] & fn_mask_q[0]);
                void'(fn_due_q.pop_front());
                void'(fn_exp_q.pop_front());
                void'(fn_mask_q.pop_front());
            end else begin
                check("fn_rvalid", bus.fn_rvalid_o, 1'b0);
            end
            check("fail", bus.fail_o, fail_ref);

            if (rst) begin
                bist_due_q.delete();
                bist_exp_q.delete();
                fn_due_q.delete();
                fn_exp_q.delete();
                fn_mask_q.delete();
                fail_ref = '0;
            end else begin
                fail_ref = (fail_ref & ~{NW{bus.fail_clr_i}}) | fails;
            end

            if (bus.bist_req_i) begin
                idx = int'(bus.bist_index_i);
                if (bus.bist_we_i) begin
                    for (int w = 0; w < NW; w++) ref_mem[w][idx] = bus.bist_pattern_i;
                end else if (!rst) begin
                    for (int w = 0; w < NW; w++)
                        res_e[w] = ((ref_mem[w][idx] ^ corrupt[w*PW +: PW]) == bus.bist_pattern_i);
                    bist_exp_q.push_back(res_e);
                    bist_due_q.push_back(cyc + LAT + 1);
                end
            end else if (bus.fn_req_i) begin
                idx = int'(bus.fn_index_i);
                if (bus.fn_we_i) begin
                    for (int w = 0; w < NW; w++)
                        if (bus.fn_way_i[w]) ref_mem[w][idx] = bus.fn_wdata_i;
                end else if (!rst) begin
                    for (int w = 0; w < NW; w++) begin
                        d_e[w*PW +: PW] = ref_mem[w][idx] ^ corrupt[w*PW +: PW];
                        m_e[w*PW +: PW] = {PW{bus.fn_way_i[w]}};
                    end
                    fn_exp_q.push_back(d_e);
                    fn_mask_q.push_back(m_e);
                    fn_due_q.push_back(cyc + LAT + 1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus.bist_req_i = 1'b0;  bus.bist_we_i = 1'b0;
        bus.bist_index_i = '0;  bus.bist_pattern_i = '0;
        bus.fn_req_i = 1'b0;    bus.fn_we_i = 1'b0;
        bus.fn_way_i = '0;      bus.fn_index_i = '0;
        bus.fn_wdata_i = '0;    bus.fail_clr_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            set_idle();
            step();
        end
    endtask

    task automatic bist_op(input bit we, input int idx, input logic [PW-1:0] pat);
        set_idle();
        bus.bist_req_i = 1'b1;
        bus.bist_we_i = we;
        bus.bist_index_i = IW'(idx);
        bus.bist_pattern_i = pat;
        step();
    endtask

    task automatic fn_op(input bit we, input logic [NW-1:0] way, input int idx, input logic [PW-1:0] d);
        set_idle();
        bus.fn_req_i = 1'b1;
        bus.fn_we_i = we;
        bus.fn_way_i = way;
        bus.fn_index_i = IW'(idx);
        bus.fn_wdata_i = d;
        step();
    endtask

    task automatic clr_op();
        set_idle();
        bus.fail_clr_i = 1'b1;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int b0, f0, idx;
        set_idle();
        corrupt = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step();
        step();
        rst = 1'b0;

        set_idle(); peek();
        check("rst_res_valid", bus.bist_res_valid_o, 1'b0);
        check("rst_res", bus.bist_res_o, '0);
        check("rst_fn_rvalid", bus.fn_rvalid_o, 1'b0);
        check("rst_fn_rdata", bus.fn_rdata_o, '0);
        check("rst_fail", bus.fail_o, '0);
        step();

        // Basic pass/fail: way 2 returns 0x00001 instead of 0.
        corrupt = DW'(1) << (2 * PW);
        bist_op(1'b1, 5, '0);
        bist_op(1'b0, 5, '0);
        idle(LAT);
        set_idle(); peek();
        check("basic_valid", bus.bist_res_valid_o, 1'b1);
        check("basic_res", bus.bist_res_o, 4'b1011);
        step();
        set_idle(); peek();
        check("basic_fail", bus.fail_o, 4'b0100);
        step();
        clr_op();
        corrupt = '0;

        // March-style all-ones write/read pass.
        for (int i = 0; i < 16; i++) bist_op(1'b1, i, '1);
        b0 = b_cnt;
        for (int i = 0; i < 16; i++) bist_op(1'b0, i, '1);
        idle(LAT + 2);
        check("march_valids", b_cnt - b0, 16);
        set_idle(); peek();
        check("march_fail", bus.fail_o, '0);
        step();

        // Arbitration: BIST wins, functional requester holds and is served next.
        b0 = b_cnt; f0 = f_cnt;
        set_idle();
        bus.bist_req_i = 1'b1; bus.bist_we_i = 1'b1;
        bus.bist_index_i = 10'd7; bus.bist_pattern_i = PW'($urandom);
        bus.fn_req_i = 1'b1; bus.fn_we_i = 1'b0;
        bus.fn_way_i = 4'b0010; bus.fn_index_i = 10'd5;
        peek();
        check("arb_gnt_lost", bus.fn_gnt_o, 1'b0);
        check("arb_req_bist", bus.sram_req_o, 4'b1111);
        step();
        bus.bist_req_i = 1'b0; bus.bist_we_i = 1'b0;
        peek();
        check("arb_gnt_won", bus.fn_gnt_o, 1'b1);
        check("arb_req_fn", bus.sram_req_o, 4'b0010);
        step();
        idle(LAT + 2);
        check("arb_fn_valids", f_cnt - f0, 1);
        check("arb_bist_valids", b_cnt - b0, 0);

        // Writes never respond.
        b0 = b_cnt; f0 = f_cnt;
        for (int i = 0; i < 8; i++) bist_op(1'b1, $urandom_range(16, 31), PW'($urandom));
        idle(LAT + 2);
        check("wr_bist_valids", b_cnt - b0, 0);
        check("wr_fn_valids", f_cnt - f0, 0);

        // Reset while three failing reads are in flight.
        corrupt = {NW{PW'(20'h00010)}};
        b0 = b_cnt; f0 = f_cnt;
        for (int i = 0; i < 3; i++) bist_op(1'b0, i, '1);
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(LAT + 4);
        check("rst_mid_bist_valids", b_cnt - b0, 0);
        check("rst_mid_fn_valids", f_cnt - f0, 0);
        set_idle(); peek();
        check("rst_mid_fail", bus.fail_o, '0);
        step();
        corrupt = '0;

        // Clear and set in the same cycle: set wins; a lone clear then clears.
        corrupt = DW'(20'h00008);
        bist_op(1'b0, 0, '1);
        idle(LAT);
        set_idle();
        bus.fail_clr_i = 1'b1;
        peek();
        check("clrset_valid", bus.bist_res_valid_o, 1'b1);
        check("clrset_res", bus.bist_res_o, 4'b1110);
        step();
        set_idle();
        bus.fail_clr_i = 1'b1;
        peek();
        check("clrset_fail", bus.fail_o, 4'b0001);
        step();
        set_idle(); peek();
        check("clr_alone_fail", bus.fail_o, '0);
        step();
        corrupt = '0;

        // Random mixed traffic with per-phase fault injection.
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < NW; w++)
                corrupt[w*PW +: PW] = ($urandom_range(0, 1) == 1) ? (PW'(1) << $urandom_range(0, PW - 1)) : '0;
            for (int i = 0; i < 60; i++) begin
                rst = (r == 3 && i == 30);
                idx = $urandom_range(0, 15);
                case ($urandom_range(0, 5))
                    0: bist_op(1'b1, idx, PW'($urandom));
                    1: bist_op(1'b0, idx, ($urandom_range(0, 2) == 0) ? PW'($urandom) : ref_mem[0][idx]);
                    2: fn_op(1'b1, NW'($urandom_range(1, 15)), idx, PW'($urandom));
                    3: fn_op(1'b0, NW'($urandom_range(1, 15)), idx, '0);
                    4: begin
                        set_idle();
                        bus.bist_req_i = 1'b1; bus.bist_we_i = 1'($urandom_range(0, 1));
                        bus.bist_index_i = IW'(idx); bus.bist_pattern_i = ref_mem[1][idx];
                        bus.fn_req_i = 1'b1; bus.fn_we_i = 1'($urandom_range(0, 1));
                        bus.fn_way_i = NW'($urandom_range(1, 15));
                        bus.fn_index_i = IW'($urandom_range(0, 15));
                        bus.fn_wdata_i = PW'($urandom);
                        step();
                    end
                    default: begin
                        set_idle();
                        bus.fail_clr_i = ($urandom_range(0, 3) == 0);
                        step();
                    end
                endcase
            end
            rst = 1'b0;
            idle(LAT + 2);
        end

        idle(LAT + 3);
        check("bist_q_drained", DW'(bist_due_q.size()), '0);
        check("fn_q_drained", DW'(fn_due_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
